// File: rtl/fnd_scan_reader.sv
// Decodes a multiplexed active-low FND bus back into per-digit values and publishes whole frames.
// Optional DP decoding: define FND_SCAN_READER_DP_EN.
module fnd_scan_reader #(
  parameter int DIGITS        = 4,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [DIGITS-1:0]     i_fnd_digit,
  input  logic [7:0]            i_fnd_font,
  output logic [4*DIGITS-1:0]   o_value,
  output logic [DIGITS-1:0]     o_blank,
  output logic [DIGITS-1:0]     o_dp,
  output logic                  o_frame_valid,
  output logic                  o_font_err,
  output logic                  o_sel_err,
  output logic [7:0]            o_err_count
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HOLD} state_t;

  typedef struct packed {
    logic       ok;
    logic       blank;
    logic       dp;
    logic [3:0] value;
  } dec_t;

  localparam logic [7:0] SETTLE_C = 8'(SETTLE_CYCLES);

  function automatic dec_t decode(input logic [7:0] font);
    dec_t       d;
    logic [7:0] f;
    d = '{ok: 1'b1, blank: 1'b0, dp: 1'b0, value: 4'hf};
`ifdef FND_SCAN_READER_DP_EN
    d.dp = ~font[7];
    f    = font | 8'h80;
`else
    f    = font;
`endif
    case (f)
      8'hc0:   d.value = 4'h0;
      8'hf9:   d.value = 4'h1;
      8'ha4:   d.value = 4'h2;
      8'hb0:   d.value = 4'h3;
      8'h99:   d.value = 4'h4;
      8'h92:   d.value = 4'h5;
      8'h82:   d.value = 4'h6;
      8'hf8:   d.value = 4'h7;
      8'h80:   d.value = 4'h8;
      8'h90:   d.value = 4'h9;
      8'hff:   d.blank = 1'b1;
`ifndef FND_SCAN_READER_DP_EN
      8'h7f:   d.value = 4'ha;
`endif
      default: d.ok    = 1'b0;
    endcase
    return d;
  endfunction

  state_t                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [DIGITS-1:0]     r_sel_q, prev_sel_q;
  logic [7:0]            r_font_q, prev_font_q;
  logic [4*DIGITS-1:0]   shadow_val_q, shadow_val_d, value_q;
  logic [DIGITS-1:0]     shadow_blank_q, shadow_blank_d, blank_q;
  logic [DIGITS-1:0]     seen_q, seen_d;
  logic                  frame_q, font_err_q, sel_err_q;
  logic                  font_err_d, sel_err_d;
  logic [7:0]            err_cnt_q, err_cnt_d;
  logic                  sel_legal, sel_idle, sel_bad, same, capture, frame_done;
  dec_t                  dec;
`ifdef FND_SCAN_READER_DP_EN
  logic [DIGITS-1:0]     shadow_dp_q, shadow_dp_d, dp_q;
`endif

  assign sel_legal  = $onehot(~r_sel_q);
  assign sel_idle   = &r_sel_q;
  assign sel_bad    = !sel_legal && !sel_idle;
  assign same       = (r_sel_q == prev_sel_q) && (r_font_q == prev_font_q);
  assign frame_done = &seen_q;
  assign dec        = decode(r_font_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sel_legal) begin
          state_d = S_SETTLE;
          cnt_d   = 8'd1;
        end
      end
      S_SETTLE: begin
        if (!sel_legal) state_d = S_IDLE;
        else if (same)  cnt_d   = cnt_q + 8'd1;
        else            cnt_d   = 8'd1;
      end
      S_HOLD: begin
        if (!sel_legal) state_d = S_IDLE;
        else if (!same) begin
          state_d = S_SETTLE;
          cnt_d   = 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Capture on the very edge the count reaches the threshold, then lock out until the pair changes.
    if (state_d == S_SETTLE && cnt_d == SETTLE_C) begin
      capture = 1'b1;
      state_d = S_HOLD;
    end
  end

  always_comb begin
    seen_d         = frame_done ? '0 : seen_q;
    shadow_val_d   = shadow_val_q;
    shadow_blank_d = shadow_blank_q;
`ifdef FND_SCAN_READER_DP_EN
    shadow_dp_d    = shadow_dp_q;
`endif
    font_err_d     = capture && !dec.ok;
    if (capture && dec.ok) begin
      for (int n = 0; n < DIGITS; n++) begin
        if (!r_sel_q[n]) begin
          shadow_val_d[4*n +: 4] = dec.value;
          shadow_blank_d[n]      = dec.blank;
`ifdef FND_SCAN_READER_DP_EN
          shadow_dp_d[n]         = dec.dp;
`endif
          seen_d[n]              = 1'b1;
        end
      end
    end
    sel_err_d = sel_bad && (r_sel_q != prev_sel_q);
    err_cnt_d = err_cnt_q;
    if ((font_err_d || sel_err_d) && err_cnt_q != 8'hff) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= 8'd0;
      r_sel_q        <= '1;
      r_font_q       <= 8'hff;
      prev_sel_q     <= '1;
      prev_font_q    <= 8'hff;
      shadow_val_q   <= '1;
      shadow_blank_q <= '0;
      seen_q         <= '0;
      value_q        <= '1;
      blank_q        <= '0;
      frame_q        <= 1'b0;
      font_err_q     <= 1'b0;
      sel_err_q      <= 1'b0;
      err_cnt_q      <= 8'd0;
`ifdef FND_SCAN_READER_DP_EN
      shadow_dp_q    <= '0;
      dp_q           <= '0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      r_sel_q        <= i_fnd_digit;
      r_font_q       <= i_fnd_font;
      prev_sel_q     <= r_sel_q;
      prev_font_q    <= r_font_q;
      shadow_val_q   <= shadow_val_d;
      shadow_blank_q <= shadow_blank_d;
      seen_q         <= seen_d;
      frame_q        <= frame_done;
      font_err_q     <= font_err_d;
      sel_err_q      <= sel_err_d;
      err_cnt_q      <= err_cnt_d;
      if (frame_done) begin
        value_q <= shadow_val_q;
        blank_q <= shadow_blank_q;
`ifdef FND_SCAN_READER_DP_EN
        dp_q    <= shadow_dp_q;
`endif
      end
`ifdef FND_SCAN_READER_DP_EN
      shadow_dp_q    <= shadow_dp_d;
`endif
    end
  end

  assign o_value       = value_q;
  assign o_blank       = blank_q;
`ifdef FND_SCAN_READER_DP_EN
  assign o_dp          = dp_q;
`else
  assign o_dp          = '0;
`endif
  assign o_frame_valid = frame_q;
  assign o_font_err    = font_err_q;
  assign o_sel_err     = sel_err_q;
  assign o_err_count   = err_cnt_q;

endmodule

// File: tb/tb_fnd_scan_reader.sv
// Bench for fnd_scan_reader: directed scenarios plus random scans checked against a dwell-level model.
module tb_fnd_scan_reader;
  localparam int D = 4;
  localparam int S = 4;

  logic           i_clk = 1'b0;
  logic           i_reset;
  logic [D-1:0]   i_fnd_digit;
  logic [7:0]     i_fnd_font;
  logic [4*D-1:0] o_value;
  logic [D-1:0]   o_blank, o_dp;
  logic           o_frame_valid, o_font_err, o_sel_err;
  logic [7:0]     o_err_count;

  fnd_scan_reader #(.DIGITS(D), .SETTLE_CYCLES(S)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_fnd_digit(i_fnd_digit), .i_fnd_font(i_fnd_font),
    .o_value(o_value), .o_blank(o_blank), .o_dp(o_dp), .o_frame_valid(o_frame_valid),
    .o_font_err(o_font_err), .o_sel_err(o_sel_err), .o_err_count(o_err_count)
  );

  always #5 i_clk = ~i_clk;

  int n_assert = 0;
  int n_fail   = 0;
  int mon_frames = 0, mon_ferr = 0, mon_serr = 0;

  always @(negedge i_clk) begin
    if (!i_reset) begin
      mon_frames += int'(o_frame_valid);
      mon_ferr   += int'(o_font_err);
      mon_serr   += int'(o_sel_err);
    end
  end

  // Reference model: works on runs of identical input pairs, not on FSM states.
  logic [7:0]   FONTS [10] = '{8'hc0, 8'hf9, 8'ha4, 8'hb0, 8'h99, 8'h92, 8'h82, 8'hf8, 8'h80, 8'h90};
  logic [D-1:0] last_sel;
  logic [7:0]   last_font;
  int           run_len;
  logic [3:0]   sh_v [D];
  logic [D-1:0] sh_b, sh_dp, seen;
  logic [4*D-1:0] m_val;
  logic [D-1:0] m_blank, m_dp;
  int           m_frames = 0, m_ferr = 0, m_serr = 0, m_cnt = 0;

  task automatic model_reset();
    last_sel = '1; last_font = 8'hff; run_len = 1;
    for (int n = 0; n < D; n++) sh_v[n] = 4'hf;
    sh_b = '0; sh_dp = '0; seen = '0;
    m_val = '1; m_blank = '0; m_dp = '0; m_cnt = 0;
  endtask

  task automatic model_capture(input int dig, input logic [7:0] font);
    logic       ok, blank, dp;
    logic [3:0] v;
    logic [7:0] f;
    ok = 1'b0; blank = 1'b0; v = 4'hf; dp = 1'b0;
`ifdef FND_SCAN_READER_DP_EN
    dp = !font[7];
    f  = font | 8'h80;
`else
    f  = font;
    if (f == 8'h7f) begin ok = 1'b1; v = 4'ha; end
`endif
    for (int i = 0; i < 10; i++) if (FONTS[i] == f) begin ok = 1'b1; v = 4'(i); end
    if (f == 8'hff) begin ok = 1'b1; blank = 1'b1; end
    if (!ok) begin
      m_ferr++;
      if (m_cnt < 255) m_cnt++;
    end else begin
      sh_v[dig] = v; sh_b[dig] = blank; sh_dp[dig] = dp; seen[dig] = 1'b1;
      if (&seen) begin
        for (int n = 0; n < D; n++) m_val[4*n +: 4] = sh_v[n];
        m_blank = sh_b; m_dp = sh_dp; m_frames++; seen = '0;
      end
    end
  endtask

  task automatic model_step(input logic [D-1:0] sel, input logic [7:0] font);
    int zeros = 0;
    int dig = 0;
    if (sel == last_sel && font == last_font) run_len++;
    else run_len = 1;
    for (int n = 0; n < D; n++) if (!sel[n]) begin zeros++; dig = n; end
    if (zeros >= 2 && sel != last_sel) begin
      m_serr++;
      if (m_cnt < 255) m_cnt++;
    end
    last_sel = sel; last_font = font;
    if (zeros == 1 && run_len == S) model_capture(dig, font);
  endtask

  task automatic cyc(input logic [D-1:0] sel, input logic [7:0] font, input int n);
    for (int k = 0; k < n; k++) begin
      i_fnd_digit = sel; i_fnd_font = font;
      @(posedge i_clk);
      model_step(sel, font);
      #1;
    end
  endtask

  task automatic dwell(input int dig, input logic [7:0] font, input int len);
    cyc(~(D'(1) << dig), font, len);
    cyc('1, 8'hff, 1);
  endtask

  task automatic do_reset(input int n);
    i_reset = 1'b1; i_fnd_digit = '1; i_fnd_font = 8'hff;
    repeat (n) @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    model_reset();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    cyc('1, 8'hff, 6);
    check({tag, ".value"},  32'(o_value), 32'(m_val));
    check({tag, ".blank"},  32'(o_blank), 32'(m_blank));
    check({tag, ".dp"},     32'(o_dp), 32'(m_dp));
    check({tag, ".errcnt"}, 32'(o_err_count), 32'(m_cnt));
    check({tag, ".frames"}, 32'(mon_frames), 32'(m_frames));
    check({tag, ".ferr"},   32'(mon_ferr), 32'(m_ferr));
    check({tag, ".serr"},   32'(mon_serr), 32'(m_serr));
  endtask

  initial begin
    logic [D-1:0] sel;
    logic [7:0]   font;
    int           r, a, b;
    i_fnd_digit = '1; i_fnd_font = 8'hff; i_reset = 1'b1;
    model_reset();
    do_reset(2);
    check("rst.value", 32'(o_value), 32'hffff);
    check("rst.pulses", {29'd0, o_frame_valid, o_font_err, o_sel_err}, 32'd0);
    check_all("reset");

    dwell(0, 8'hc0, 6); dwell(1, 8'hf9, 6); dwell(2, 8'ha4, 6); dwell(3, 8'hb0, 6);
    check_all("normal");

    dwell(0, 8'h99, 6); dwell(1, 8'h92, 6); dwell(2, 8'h82, 3); dwell(3, 8'hf8, 6);
    check_all("short");
    dwell(2, 8'h82, 6);
    check_all("short_fix");

    dwell(0, 8'h92, 6); dwell(1, 8'h55, 6); dwell(2, 8'hf8, 6); dwell(3, 8'h80, 6);
    check_all("fonterr");
    dwell(1, 8'h90, 6);
    check_all("fonterr_fix");

    cyc(4'b1100, 8'hc0, 5); cyc('1, 8'hff, 1);
    check_all("selerr");
    dwell(0, 8'hf9, 6); dwell(1, 8'h7f, 6); dwell(2, 8'hb0, 6); dwell(3, 8'hff, 6);
    check_all("blank");

    dwell(0, 8'h80, 6); dwell(1, 8'h99, 6);
    cyc('1, 8'hff, 5);
    do_reset(2);
    check_all("midrst");
    dwell(0, 8'ha4, 6); dwell(1, 8'hc0, 6); dwell(2, 8'h90, 6); dwell(3, 8'h82, 6);
    check_all("postrst");

`ifdef FND_SCAN_READER_DP_EN
    dwell(0, 8'h40, 6); dwell(1, 8'h79, 6); dwell(2, 8'h7f, 6); dwell(3, 8'hb0, 6);
    check_all("dp");
`endif

    for (int it = 0; it < 200; it++) begin
      r = $urandom_range(0, 9);
      if (r < 7) begin
        sel = ~(D'(1) << $urandom_range(0, D-1));
      end else if (r == 7) begin
        a = $urandom_range(0, D-1);
        b = (a + $urandom_range(1, D-1)) % D;
        sel = ~((D'(1) << a) | (D'(1) << b));
      end else begin
        sel = '1;
      end
      if ($urandom_range(0, 9) < 7) font = FONTS[$urandom_range(0, 9)];
      else font = 8'($urandom);
      cyc(sel, font, $urandom_range(1, 7));
      cyc('1, 8'hff, $urandom_range(0, 2));
      if (it % 40 == 39) check_all("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
